// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry pipeline stage register.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

   localparam int PIPE_DEPTH = 2;
   localparam int OCC_W      = $clog2(PIPE_DEPTH + 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
      logic [OCC_W-1:0] n;
      n = '0;
      case (s)
         EMPTY:   n = OCC_W'(0);
         ONE:     n = OCC_W'(1);
         FULL:    n = OCC_W'(2);
         default: n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/reg_en.sv
// WIDTH-wide register with load enable and asynchronous active-low clear.
module reg_en #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline stage: main drives out_data, skid absorbs one beat
// under backpressure so in_ready can be a pure function of registered state.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter bit FLUSH_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       occupancy
);

   pipe_state_t      state, state_nxt;
   logic             accept, emit, kill;
   logic             main_en, skid_en, main_from_skid;
   logic [WIDTH-1:0] main_d, skid_q;

   // Status outputs come straight off the state register.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign occupancy = 2'(occ_of(state));

   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready;
   assign kill   = FLUSH_EN && flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (kill) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) state_nxt = ONE;
            ONE: begin
               if (accept && !emit)      state_nxt = FULL;
               else if (!accept && emit) state_nxt = EMPTY;
            end
            FULL:    if (emit) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Flush suppresses every load so squashed beats never touch the datapath.
   always_comb begin
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
      if (!kill) begin
         case (state)
            EMPTY: main_en = accept;
            ONE: begin
               if (accept && emit) main_en = 1'b1;
               else if (accept)    skid_en = 1'b1;
            end
            FULL: begin
               main_en        = emit;
               main_from_skid = emit;
            end
            default: ;
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   reg_en #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (out_data)
   );

   reg_en #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .reset (reset),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg against hand values and a
// reference queue.
module tb_pipe_stage_reg;

   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_ready, out_valid, out_ready, flush;
   logic [WIDTH-1:0] in_data, out_data;
   logic [1:0]       occupancy;

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(.WIDTH(WIDTH), .FLUSH_EN(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic status(input string tag, input logic v, input logic r, input logic [1:0] occ);
      chk({tag, "_valid"}, 64'(out_valid), 64'(v));
      chk({tag, "_ready"}, 64'(in_ready), 64'(r));
      chk({tag, "_occ"}, 64'(occupancy), 64'(occ));
   endtask

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] seq;
   logic             acc, emt;

   initial begin
      reset = 1'b0; in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b0; flush = 1'b0;

      // reset held with an offered beat
      for (int i = 0; i < 3; i++) begin
         step();
         status("rst", 1'b0, 1'b1, 2'd0);
         chk("rst_data", out_data, 64'h0);
      end
      reset = 1'b1;
      step();
      status("first_acc", 1'b1, 1'b1, 2'd1);
      chk("first_acc_data", out_data, 64'hAA);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      status("drain0", 1'b0, 1'b1, 2'd0);

      // streaming
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_data = 64'(i);
         step();
         status("stream", 1'b1, 1'b1, 2'd1);
         chk("stream_data", out_data, 64'(i));
      end
      in_valid = 1'b0;
      step();
      status("stream_end", 1'b0, 1'b1, 2'd0);

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h10;
      step();
      status("bp1", 1'b1, 1'b1, 2'd1);
      chk("bp1_data", out_data, 64'h10);
      in_data = 64'h11;
      step();
      status("bp2", 1'b1, 1'b0, 2'd2);
      chk("bp2_data", out_data, 64'h10);
      in_valid = 1'b0;
      step();
      status("bp_hold", 1'b1, 1'b0, 2'd2);
      chk("bp_hold_data", out_data, 64'h10);
      out_ready = 1'b1;
      step();
      status("bp_emit1", 1'b1, 1'b1, 2'd1);
      chk("bp_emit1_data", out_data, 64'h11);
      step();
      status("bp_emit2", 1'b0, 1'b1, 2'd0);

      // flush from FULL with a same-cycle offered beat
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h20;
      step();
      in_data = 64'h21;
      step();
      status("fl_full", 1'b1, 1'b0, 2'd2);
      flush = 1'b1; in_data = 64'h22;
      step();
      status("flush", 1'b0, 1'b1, 2'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         status("post_flush", 1'b0, 1'b1, 2'd0);
      end

      // flush from ONE overriding accept+emit
      in_valid = 1'b1; in_data = 64'h23;
      step();
      in_data = 64'h24; flush = 1'b1;
      step();
      status("flush_one", 1'b0, 1'b1, 2'd0);
      flush = 1'b0; in_valid = 1'b0;

      // asynchronous reset between edges
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30;
      step();
      in_data = 64'h31;
      step();
      status("ar_full", 1'b1, 1'b0, 2'd2);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      status("async_rst", 1'b0, 1'b1, 2'd0);
      chk("async_rst_data", out_data, 64'h0);
      #1 reset = 1'b1;
      step();
      status("ar_release", 1'b0, 1'b1, 2'd0);
      chk("ar_skid", dut.skid_q, 64'h0);

      // randomised traffic against a reference queue
      seq = 64'h1000;
      for (int c = 0; c < 1000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = seq;
         chk("rnd_occ", 64'(occupancy), 64'(q.size()));
         chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("rnd_ready", 64'(in_ready), 64'(q.size() < 2));
         if (q.size() != 0) chk("rnd_data", out_data, q[0]);
         acc = in_valid && (q.size() < 2);
         emt = out_ready && (q.size() != 0);
         if (emt) void'(q.pop_front());
         if (acc) begin
            q.push_back(seq);
            seq++;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
